gpu_fill_arbiter: RTL and testbench

GPU_FILL_ARBITER -- requirements
Module: gpu_fill_arbiter

---
 rtl/gpu_fill_arbiter.sv | 115 +++++++++++
 tb/tb_gpu_fill_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fill_arbiter.sv
// gpu_fill_arbiter: arbitrates L/R texture and CLUT cache line fills onto one memory port
module gpu_fill_arbiter (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic [1:0]  GPU_REG_TexFormat,
  input  logic        requTexCacheUpdateL,
  input  logic        requTexCacheUpdateR,
  input  logic [16:0] adrTexCacheUpdateL,
  input  logic [16:0] adrTexCacheUpdateR,
  output logic        updateTexCacheCompleteL,
  output logic        updateTexCacheCompleteR,
  input  logic        requClutCacheUpdateL,
  input  logic        requClutCacheUpdateR,
  input  logic [14:0] adrClutCacheUpdateL,
  input  logic [14:0] adrClutCacheUpdateR,
  output logic        updateClutCacheCompleteL,
  output logic        updateClutCacheCompleteR,
  output logic        o_memReq,
  output logic [16:0] o_memAdr,
  output logic [6:0]  o_memBeats,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [63:0] i_memData,
  output logic        o_memDataReady,
  output logic        TexCacheWrite,
  output logic [16:0] adrTexCacheWrite,
  output logic [63:0] TexCacheData,
  output logic        ClutCacheWrite,
  output logic [6:0]  ClutWriteIndex,
  output logic [31:0] ClutCacheData
);
  typedef enum logic [2:0] {IDLE, MEMREQ, TEXDATA, CLUTLO, CLUTHI, DONE} state_t;
  state_t      state_q;
  logic [16:0] adr_q;
  logic        clut_q, fmt8_q, srv_l_q, srv_r_q, side_q, last_tex_r_q, last_clut_r_q;
  logic [6:0]  cnt_q, cnt_nxt;
  logic [31:0] hi_q;
  logic        clut_sel, req_l, req_r, same, pick_r, srv_both, go, tex_wr, lo_wr, last_beat, done;
  logic [16:0] adr_l, adr_r;
  // CLUT class wins outright; within a class equal addresses are merged, otherwise alternate
  assign clut_sel  = requClutCacheUpdateL | requClutCacheUpdateR;
  assign req_l     = clut_sel ? requClutCacheUpdateL : requTexCacheUpdateL;
  assign req_r     = clut_sel ? requClutCacheUpdateR : requTexCacheUpdateR;
  assign adr_l     = clut_sel ? {adrClutCacheUpdateL, 2'b00} : adrTexCacheUpdateL;
  assign adr_r     = clut_sel ? {adrClutCacheUpdateR, 2'b00} : adrTexCacheUpdateR;
  assign same      = adr_l == adr_r;
  assign srv_both  = req_l & req_r & same;
  assign pick_r    = (req_l & req_r) ? (!same & !(clut_sel ? last_clut_r_q : last_tex_r_q)) : req_r;
  assign go        = req_l | req_r;
  assign tex_wr    = (state_q == TEXDATA) & i_memDataValid;
  assign lo_wr     = (state_q == CLUTLO) & i_memDataValid;
  assign cnt_nxt   = cnt_q + 7'd1;
  assign last_beat = fmt8_q ? (cnt_nxt == 7'd0) : (cnt_nxt == 7'd8);
  assign done      = state_q == DONE;
  assign o_memReq         = state_q == MEMREQ;
  assign o_memAdr         = adr_q;
  assign o_memBeats       = o_memReq ? (clut_q ? (fmt8_q ? 7'd64 : 7'd4) : 7'd1) : 7'd0;
  assign o_memDataReady   = (state_q == TEXDATA) | (state_q == CLUTLO);
  assign TexCacheWrite    = tex_wr;
  assign adrTexCacheWrite = adr_q;
  assign TexCacheData     = tex_wr ? i_memData : 64'd0;
  assign ClutCacheWrite   = lo_wr | (state_q == CLUTHI);
  assign ClutWriteIndex   = cnt_q;
  assign ClutCacheData    = lo_wr ? i_memData[31:0] : ((state_q == CLUTHI) ? hi_q : 32'd0);
  assign updateTexCacheCompleteL  = done & !clut_q & srv_l_q;
  assign updateTexCacheCompleteR  = done & !clut_q & srv_r_q;
  assign updateClutCacheCompleteL = done & clut_q & srv_l_q;
  assign updateClutCacheCompleteR = done & clut_q & srv_r_q;
  // Fill sequencer: grant, memory request, data beats, completion
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q       <= IDLE;
      adr_q         <= '0;
      clut_q        <= 1'b0;
      fmt8_q        <= 1'b0;
      srv_l_q       <= 1'b0;
      srv_r_q       <= 1'b0;
      side_q        <= 1'b0;
      last_tex_r_q  <= 1'b1;
      last_clut_r_q <= 1'b1;
      cnt_q         <= '0;
      hi_q          <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          adr_q   <= pick_r ? adr_r : adr_l;
          clut_q  <= clut_sel;
          fmt8_q  <= GPU_REG_TexFormat[0];
          srv_l_q <= !pick_r | srv_both;
          srv_r_q <= pick_r | srv_both;
          side_q  <= pick_r;
          cnt_q   <= '0;
          state_q <= (clut_sel & GPU_REG_TexFormat[1]) ? DONE : MEMREQ;
        end
        MEMREQ:  if (i_memAck) state_q <= clut_q ? CLUTLO : TEXDATA;
        TEXDATA: if (i_memDataValid) state_q <= DONE;
        CLUTLO: if (i_memDataValid) begin
          hi_q    <= i_memData[63:32];
          cnt_q   <= cnt_nxt;
          state_q <= CLUTHI;
        end
        CLUTHI: begin
          cnt_q   <= cnt_nxt;
          state_q <= last_beat ? DONE : CLUTLO;
        end
        DONE: begin
          if (clut_q) last_clut_r_q <= side_q;
          else last_tex_r_q <= side_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_fill_arbiter.sv
// tb_gpu_fill_arbiter: directed bench with a small memory responder and write/complete monitors
module tb_gpu_fill_arbiter;
  logic clk = 0, i_nrst = 0;
  logic [1:0] GPU_REG_TexFormat = 0;
  logic requTexCacheUpdateL = 0, requTexCacheUpdateR = 0;
  logic [16:0] adrTexCacheUpdateL = 0, adrTexCacheUpdateR = 0;
  logic updateTexCacheCompleteL, updateTexCacheCompleteR;
  logic requClutCacheUpdateL = 0, requClutCacheUpdateR = 0;
  logic [14:0] adrClutCacheUpdateL = 0, adrClutCacheUpdateR = 0;
  logic updateClutCacheCompleteL, updateClutCacheCompleteR;
  logic o_memReq, o_memDataReady, i_memAck = 0, i_memDataValid = 0;
  logic [16:0] o_memAdr;
  logic [6:0] o_memBeats;
  logic [63:0] i_memData = 0;
  logic TexCacheWrite, ClutCacheWrite;
  logic [16:0] adrTexCacheWrite;
  logic [63:0] TexCacheData;
  logic [6:0] ClutWriteIndex;
  logic [31:0] ClutCacheData;

  always #5 clk = ~clk;

  gpu_fill_arbiter dut (
    .clk(clk), .i_nrst(i_nrst), .GPU_REG_TexFormat(GPU_REG_TexFormat),
    .requTexCacheUpdateL(requTexCacheUpdateL), .requTexCacheUpdateR(requTexCacheUpdateR),
    .adrTexCacheUpdateL(adrTexCacheUpdateL), .adrTexCacheUpdateR(adrTexCacheUpdateR),
    .updateTexCacheCompleteL(updateTexCacheCompleteL), .updateTexCacheCompleteR(updateTexCacheCompleteR),
    .requClutCacheUpdateL(requClutCacheUpdateL), .requClutCacheUpdateR(requClutCacheUpdateR),
    .adrClutCacheUpdateL(adrClutCacheUpdateL), .adrClutCacheUpdateR(adrClutCacheUpdateR),
    .updateClutCacheCompleteL(updateClutCacheCompleteL), .updateClutCacheCompleteR(updateClutCacheCompleteR),
    .o_memReq(o_memReq), .o_memAdr(o_memAdr), .o_memBeats(o_memBeats), .i_memAck(i_memAck),
    .i_memDataValid(i_memDataValid), .i_memData(i_memData), .o_memDataReady(o_memDataReady),
    .TexCacheWrite(TexCacheWrite), .adrTexCacheWrite(adrTexCacheWrite), .TexCacheData(TexCacheData),
    .ClutCacheWrite(ClutCacheWrite), .ClutWriteIndex(ClutWriteIndex), .ClutCacheData(ClutCacheData)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_req, n_tw, n_cw, n_tl, n_tr, n_cl, n_cr, tl_cyc, tr_cyc, cl_cyc, cr_cyc, tw_cyc;
  int clut_bad, rdy_bad, stab_bad, exp_idx, w = 0, b = 0;
  logic [16:0] adr_log [4];
  logic [6:0] beats_log [4];
  logic [16:0] tw_adr, req_adr;
  logic [63:0] tw_data, tex_word = 0;
  logic prev_req = 0, hit37 = 0, tex_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_req = 0; n_tw = 0; n_cw = 0; n_tl = 0; n_tr = 0; n_cl = 0; n_cr = 0;
    tl_cyc = -1; tr_cyc = -1; cl_cyc = -1; cr_cyc = -1; tw_cyc = -1;
    clut_bad = 0; rdy_bad = 0; stab_bad = 0; exp_idx = 0; hit37 = 0;
    for (int i = 0; i < 4; i++) begin adr_log[i] = '0; beats_log[i] = '0; end
  endtask

  function automatic logic any_req();
    return requTexCacheUpdateL | requTexCacheUpdateR | requClutCacheUpdateL | requClutCacheUpdateR;
  endfunction

  // One cycle: memory responder drives at the falling edge, monitors sample 1ns later
  task automatic step();
    @(negedge clk);
    cyc++;
    i_memAck = o_memReq && (w == 2);
    w = o_memReq ? w + 1 : 0;
    if (o_memReq) b = 0;
    i_memDataValid = o_memDataReady;
    i_memData = tex_mode ? tex_word : {32'hA000_0000 | 32'(2 * b + 1), 32'hA000_0000 | 32'(2 * b)};
    if (o_memDataReady) b++;
    #1;
    if (o_memReq && !prev_req) begin
      if (n_req < 4) begin adr_log[n_req] = o_memAdr; beats_log[n_req] = o_memBeats; end
      n_req++;
      req_adr = o_memAdr;
    end
    if (o_memReq && prev_req && o_memAdr !== req_adr) stab_bad++;
    prev_req = o_memReq;
    if (TexCacheWrite) begin n_tw++; tw_cyc = cyc; tw_adr = adrTexCacheWrite; tw_data = TexCacheData; end
    if (ClutCacheWrite) begin
      if (int'(ClutWriteIndex) != exp_idx || ClutCacheData !== (32'hA000_0000 | 32'(exp_idx))) clut_bad++;
      if (exp_idx % 2 == 1 && o_memDataReady) rdy_bad++;
      if (ClutWriteIndex == 7'd37 && !o_memDataReady) hit37 = 1;
      exp_idx++;
      n_cw++;
    end
    if (updateTexCacheCompleteL) begin n_tl++; tl_cyc = cyc; requTexCacheUpdateL = 0; end
    if (updateTexCacheCompleteR) begin n_tr++; tr_cyc = cyc; requTexCacheUpdateR = 0; end
    if (updateClutCacheCompleteL) begin n_cl++; cl_cyc = cyc; requClutCacheUpdateL = 0; end
    if (updateClutCacheCompleteR) begin n_cr++; cr_cyc = cyc; requClutCacheUpdateR = 0; end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (any_req() && n < budget) begin step(); n++; end
    chk("timeout", 64'(n < budget), 1);
    step();
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_nrst = 0; i_memAck = 0; i_memDataValid = 0; w = 0; b = 0; prev_req = 0;
    @(negedge clk);
    i_nrst = 1;
  endtask

  initial begin
    clr();
    repeat (2) @(negedge clk);
    chk("rst_memreq", o_memReq, 0);
    chk("rst_ready", o_memDataReady, 0);
    chk("rst_adr", o_memAdr, 0);
    chk("rst_idx", ClutWriteIndex, 0);
    chk("rst_cmpl", {updateTexCacheCompleteL, updateTexCacheCompleteR, updateClutCacheCompleteL, updateClutCacheCompleteR}, 0);
    i_nrst = 1;

    // single texture fill from L
    clr(); tex_mode = 1; tex_word = 64'hDEADBEEF_01234567;
    adrTexCacheUpdateL = 17'h00123; requTexCacheUpdateL = 1;
    run(50);
    chk("tex_nreq", n_req, 1);
    chk("tex_adr", adr_log[0], 17'h00123);
    chk("tex_beats", beats_log[0], 1);
    chk("tex_nwr", n_tw, 1);
    chk("tex_wadr", tw_adr, 17'h00123);
    chk("tex_wdata", tw_data, 64'hDEADBEEF_01234567);
    chk("tex_cmpl_lat", tl_cyc - tw_cyc, 1);
    chk("tex_ncl", n_tl, 1);
    chk("tex_ncr", n_tr, 0);
    chk("tex_stable", stab_bad, 0);

    // equal addresses merge into one memory request
    clr();
    adrTexCacheUpdateL = 17'h00040; adrTexCacheUpdateR = 17'h00040;
    requTexCacheUpdateL = 1; requTexCacheUpdateR = 1;
    run(50);
    chk("merge_nreq", n_req, 1);
    chk("merge_ncl", n_tl, 1);
    chk("merge_ncr", n_tr, 1);
    chk("merge_same", tl_cyc, tr_cyc);

    // alternation of differing addresses
    do_reset();
    clr();
    adrTexCacheUpdateL = 17'h00010; adrTexCacheUpdateR = 17'h00020;
    requTexCacheUpdateL = 1; requTexCacheUpdateR = 1;
    run(100);
    chk("alt1_nreq", n_req, 2);
    chk("alt1_first", adr_log[0], 17'h00010);
    chk("alt1_second", adr_log[1], 17'h00020);
    chk("alt1_order", 64'(tl_cyc < tr_cyc), 1);
    clr();
    requTexCacheUpdateL = 1;
    run(50);
    clr();
    requTexCacheUpdateL = 1; requTexCacheUpdateR = 1;
    run(100);
    chk("alt2_first", adr_log[0], 17'h00020);
    chk("alt2_order", 64'(tr_cyc < tl_cyc), 1);

    // 8bpp CLUT load
    clr(); tex_mode = 0; GPU_REG_TexFormat = 1;
    adrClutCacheUpdateL = {9'd5, 6'd3}; requClutCacheUpdateL = 1;
    run(400);
    chk("c8_adr", adr_log[0], 17'h0050C);
    chk("c8_beats", beats_log[0], 64);
    chk("c8_nwr", n_cw, 128);
    chk("c8_seq", clut_bad, 0);
    chk("c8_rdy_hi", rdy_bad, 0);
    chk("c8_ncl", n_cl, 1);
    chk("c8_ncr", n_cr, 0);

    // CLUT beats pending texture
    clr(); GPU_REG_TexFormat = 0;
    adrClutCacheUpdateR = {9'd1, 6'd2}; requClutCacheUpdateR = 1;
    adrTexCacheUpdateL = 17'h00077; requTexCacheUpdateL = 1;
    run(100);
    chk("c4_adr", adr_log[0], 17'h00108);
    chk("c4_beats", beats_log[0], 4);
    chk("c4_tex_adr", adr_log[1], 17'h00077);
    chk("c4_tex_beats", beats_log[1], 1);
    chk("c4_nwr", n_cw, 8);
    chk("c4_seq", clut_bad, 0);
    chk("c4_order", 64'(cr_cyc < tl_cyc), 1);
    chk("c4_ntw", n_tw, 1);

    // true-colour CLUT request completes without memory
    clr(); GPU_REG_TexFormat = 2;
    adrClutCacheUpdateL = 15'h0ABC; requClutCacheUpdateL = 1;
    run(20);
    chk("tc_nreq", n_req, 0);
    chk("tc_ncl", n_cl, 1);
    chk("tc_nwr", n_cw, 0);

    // reset mid-fill at index 37
    clr(); GPU_REG_TexFormat = 1;
    adrClutCacheUpdateL = {9'd5, 6'd3}; requClutCacheUpdateL = 1;
    for (int n = 0; n < 200 && !hit37; n++) step();
    chk("abort_hit37", hit37, 1);
    i_nrst = 0; i_memAck = 0; i_memDataValid = 0; w = 0; b = 0; prev_req = 0;
    #1;
    chk("abort_cw", ClutCacheWrite, 0);
    chk("abort_idx", ClutWriteIndex, 0);
    chk("abort_data", ClutCacheData, 0);
    chk("abort_ready", o_memDataReady, 0);
    chk("abort_ncl", n_cl, 0);
    @(negedge clk);
    chk("abort_cmpl", updateClutCacheCompleteL, 0);
    i_nrst = 1;
    clr();
    run(400);
    chk("restart_adr", adr_log[0], 17'h0050C);
    chk("restart_nwr", n_cw, 128);
    chk("restart_seq", clut_bad, 0);
    chk("restart_ncl", n_cl, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
